// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions.
//   - opcode localparams for the base integer ISA
//   - alu_op_e   : operation requested of the EX-stage ALU
//   - imm_type_e : immediate format selector used by the decoder
//   - id_ctrl_t  : control bundle carried through the ID/EX register
//   - gen_imm()  : immediate extraction + sign extension
//   - alu_from_funct() : funct3/funct7 -> ALU operation for OP / OP-IMM
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  // mem_size carries funct3 for loads/stores (width + sign) and for
  // branches (compare condition); zero otherwise.
  typedef struct packed {
    alu_op_e    alu_op;
    logic       src_a_pc;
    logic       src_b_imm;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] mem_size;
    logic       branch;
    logic       jump;
    logic       illegal;
  } id_ctrl_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_type_e t);
    logic [31:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_id_stage_decoder.sv
// riscv_decoder: purely combinational RV32I instruction decoder.
//   inst_i  : instruction word
//   ctrl_o  : control bundle (illegal=1 for unknown opcode/funct)
//   imm_o   : sign-extended immediate (0 for R-type / illegal)
//   rs1_o, rs2_o : source indices, zeroed when the source is not read
//   rd_o    : destination index, zeroed when nothing is written
//   re1_o, re2_o : register read enables
module riscv_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] inst_i,
  output id_ctrl_t    ctrl_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        re1_o,
  output logic        re2_o
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  imm_type_e  imm_t;
  logic       legal, wr_rd, re1, re2;
  id_ctrl_t   ctrl;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    imm_t       = IMM_NONE;
    legal       = 1'b0;
    wr_rd       = 1'b0;
    re1         = 1'b0;
    re2         = 1'b0;
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; imm_t = IMM_U; wr_rd = 1'b1;
        ctrl.alu_op = ALU_PASS_B; ctrl.src_b_imm = 1'b1; ctrl.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; imm_t = IMM_U; wr_rd = 1'b1;
        ctrl.src_a_pc = 1'b1; ctrl.src_b_imm = 1'b1; ctrl.reg_we = 1'b1;
      end
      OPC_JAL: begin
        // ALU forms the target pc+imm; link value is produced in EX.
        legal = 1'b1; imm_t = IMM_J; wr_rd = 1'b1;
        ctrl.src_a_pc = 1'b1; ctrl.src_b_imm = 1'b1; ctrl.reg_we = 1'b1; ctrl.jump = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0); imm_t = IMM_I; wr_rd = 1'b1; re1 = 1'b1;
        ctrl.src_b_imm = 1'b1; ctrl.reg_we = 1'b1; ctrl.jump = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3); imm_t = IMM_B; re1 = 1'b1; re2 = 1'b1;
        ctrl.branch = 1'b1; ctrl.mem_size = f3;
        case (f3[2:1])
          2'b10:   ctrl.alu_op = ALU_SLT;
          2'b11:   ctrl.alu_op = ALU_SLTU;
          default: ctrl.alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        imm_t = IMM_I; wr_rd = 1'b1; re1 = 1'b1;
        ctrl.src_b_imm = 1'b1; ctrl.reg_we = 1'b1; ctrl.mem_rd = 1'b1; ctrl.mem_size = f3;
      end
      OPC_STORE: begin
        legal = (f3 < 3'd3); imm_t = IMM_S; re1 = 1'b1; re2 = 1'b1;
        ctrl.src_b_imm = 1'b1; ctrl.mem_wr = 1'b1; ctrl.mem_size = f3;
      end
      OPC_OP_IMM: begin
        // Shift-immediates reuse the upper imm bits as funct7.
        if (f3 == 3'd1)      legal = (f7 == F7_BASE);
        else if (f3 == 3'd5) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                 legal = 1'b1;
        imm_t = IMM_I; wr_rd = 1'b1; re1 = 1'b1;
        ctrl.src_b_imm = 1'b1; ctrl.reg_we = 1'b1;
        ctrl.alu_op = alu_from_funct(f3, (f3 == 3'd5) && inst_i[30]);
      end
      OPC_OP: begin
        legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5)));
        wr_rd = 1'b1; re1 = 1'b1; re2 = 1'b1;
        ctrl.reg_we = 1'b1;
        ctrl.alu_op = alu_from_funct(f3, inst_i[30]);
      end
      OPC_FENCE: legal = 1'b1;  // single-hart in-order core: no-op
      default:   legal = 1'b0;
    endcase

    // Illegal instructions still flow down the pipe but with no side effects.
    if (!legal) begin
      ctrl         = '0;
      ctrl.alu_op  = ALU_ADD;
      ctrl.illegal = 1'b1;
      imm_t        = IMM_NONE;
      wr_rd        = 1'b0;
      re1          = 1'b0;
      re2          = 1'b0;
    end
  end

  assign ctrl_o = ctrl;
  assign imm_o  = gen_imm(inst_i, imm_t);
  assign re1_o  = re1;
  assign re2_o  = re2;
  assign rs1_o  = re1   ? inst_i[19:15] : 5'd0;
  assign rs2_o  = re2   ? inst_i[24:20] : 5'd0;
  assign rd_o   = wr_rd ? inst_i[11:7]  : 5'd0;

endmodule

// File: rtl/riscv_id_stage.sv
// riscv_id_stage: RV32I decode stage and ID/EX pipeline register.
//   IF/ID side : i_if_valid, i_if_pc, i_if_inst, o_id_ready (handshake)
//   EX side    : i_ex_ready, o_ex_valid, o_ex_pc/imm/rs1/rs2/rd/ctrl,
//                o_ex_rs1_data/o_ex_rs2_data (regfile data, passed through)
//   Regfile    : o_re1/2, o_raddr1/2 out; i_rdata1/2 in (1-cycle sync read)
//   i_flush    : kills ID/EX contents and the instruction on IF/ID
// The regfile is addressed in the same cycle ID/EX loads, so its read data
// lines up with the ID/EX register and is forwarded straight to EX.
module riscv_id_stage
  import riscv_pkg::*;
#(
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_inst,
  output logic        o_id_ready,
  input  logic        i_ex_ready,
  input  logic        i_flush,
  output logic        o_re1,
  output logic        o_re2,
  output logic [4:0]  o_raddr1,
  output logic [4:0]  o_raddr2,
  input  logic [31:0] i_rdata1,
  input  logic [31:0] i_rdata2,
  output logic        o_ex_valid,
  output logic [31:0] o_ex_pc,
  output logic [31:0] o_ex_imm,
  output logic [4:0]  o_ex_rs1,
  output logic [4:0]  o_ex_rs2,
  output logic [4:0]  o_ex_rd,
  output logic [31:0] o_ex_rs1_data,
  output logic [31:0] o_ex_rs2_data,
  output id_ctrl_t    o_ex_ctrl
);

  // decode of the instruction sitting on IF/ID
  id_ctrl_t    dec_ctrl;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_re1, dec_re2;

  riscv_decoder u_dec (
    .inst_i (i_if_inst),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm),
    .rs1_o  (dec_rs1),
    .rs2_o  (dec_rs2),
    .rd_o   (dec_rd),
    .re1_o  (dec_re1),
    .re2_o  (dec_re2)
  );

  // ID/EX register
  logic        ex_valid_q;
  logic [31:0] ex_pc_q, ex_imm_q;
  logic [4:0]  ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic        ex_re1_q, ex_re2_q;
  id_ctrl_t    ex_ctrl_q;

  logic hazard, hold, acc;

  // A load in EX has no data until MEM; a dependent consumer waits one cycle.
  assign hazard = LOAD_USE_STALL && ex_valid_q && ex_ctrl_q.mem_rd && (ex_rd_q != 5'd0) &&
                  ((dec_re1 && (dec_rs1 == ex_rd_q)) || (dec_re2 && (dec_rs2 == ex_rd_q)));

  assign hold = ex_valid_q && !i_ex_ready && !i_flush;

  // rst_n gates ready so nothing is accepted while reset is held.
  assign o_id_ready = rst_n && !i_flush && !hazard && (!ex_valid_q || i_ex_ready);
  assign acc        = i_if_valid && o_id_ready;

  // Read ports: during a hold keep re-reading the held sources so the
  // regfile output stays aligned with the frozen ID/EX contents.
  always_comb begin
    o_re1    = 1'b0;
    o_re2    = 1'b0;
    o_raddr1 = 5'd0;
    o_raddr2 = 5'd0;
    if (hold) begin
      o_re1    = ex_re1_q;
      o_re2    = ex_re2_q;
      o_raddr1 = ex_rs1_q;
      o_raddr2 = ex_rs2_q;
    end else if (acc) begin
      o_re1    = dec_re1;
      o_re2    = dec_re2;
      o_raddr1 = dec_rs1;
      o_raddr2 = dec_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_re1_q   <= 1'b0;
      ex_re2_q   <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (i_flush) begin
      ex_valid_q <= 1'b0;
    end else if (!hold) begin
      // Bubble leaves stale fields behind; only valid matters then.
      ex_valid_q <= acc;
      if (acc) begin
        ex_pc_q   <= i_if_pc;
        ex_imm_q  <= dec_imm;
        ex_rs1_q  <= dec_rs1;
        ex_rs2_q  <= dec_rs2;
        ex_rd_q   <= dec_rd;
        ex_re1_q  <= dec_re1;
        ex_re2_q  <= dec_re2;
        ex_ctrl_q <= dec_ctrl;
      end
    end
  end

  assign o_ex_valid    = ex_valid_q;
  assign o_ex_pc       = ex_pc_q;
  assign o_ex_imm      = ex_imm_q;
  assign o_ex_rs1      = ex_rs1_q;
  assign o_ex_rs2      = ex_rs2_q;
  assign o_ex_rd       = ex_rd_q;
  assign o_ex_ctrl     = ex_ctrl_q;
  assign o_ex_rs1_data = i_rdata1;
  assign o_ex_rs2_data = i_rdata2;

endmodule

// File: tb/tb_riscv_id_stage.sv
module tb_riscv_id_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_if_valid = 1'b0;
  logic [31:0] i_if_pc = '0;
  logic [31:0] i_if_inst = '0;
  logic        o_id_ready;
  logic        i_ex_ready = 1'b1;
  logic        i_flush = 1'b0;
  logic        o_re1, o_re2;
  logic [4:0]  o_raddr1, o_raddr2;
  logic [31:0] i_rdata1 = '0;
  logic [31:0] i_rdata2 = '0;
  logic        o_ex_valid;
  logic [31:0] o_ex_pc, o_ex_imm;
  logic [4:0]  o_ex_rs1, o_ex_rs2, o_ex_rd;
  logic [31:0] o_ex_rs1_data, o_ex_rs2_data;
  id_ctrl_t    o_ex_ctrl;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  typedef struct {
    logic [31:0] inst, pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        re1, re2, we, mrd, mwr, br, jmp, ill;
  } exp_t;

  exp_t tbl [12];
  exp_t q [$];

  riscv_id_stage #(.LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_valid(i_if_valid), .i_if_pc(i_if_pc), .i_if_inst(i_if_inst),
    .o_id_ready(o_id_ready), .i_ex_ready(i_ex_ready), .i_flush(i_flush),
    .o_re1(o_re1), .o_re2(o_re2), .o_raddr1(o_raddr1), .o_raddr2(o_raddr2),
    .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
    .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_imm(o_ex_imm),
    .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd),
    .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
    .o_ex_ctrl(o_ex_ctrl)
  );

  always #5 clk = ~clk;

  // regfile model: synchronous read, x0 hard-wired to zero
  always @(posedge clk) begin
    if (o_re1) i_rdata1 <= (o_raddr1 == 5'd0) ? 32'd0 : regs[o_raddr1];
    if (o_re2) i_rdata2 <= (o_raddr2 == 5'd0) ? 32'd0 : regs[o_raddr2];
  end

  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic re1, input logic re2, input logic we, input logic mrd,
                              input logic mwr, input logic br, input logic jmp, input logic ill);
    exp_t e;
    e.inst = inst; e.pc = '0; e.imm = imm; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.re1 = re1; e.re2 = re2; e.we = we; e.mrd = mrd; e.mwr = mwr;
    e.br = br; e.jmp = jmp; e.ill = ill;
    return e;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; i_if_valid = 1'b1; i_if_inst = 32'h00500093; i_ex_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_ex_valid); end
    checks++; if ({o_ex_pc, o_ex_imm, o_ex_rd, o_ex_rs1, o_ex_rs2} !== '0)
      begin errors++; $display("FAIL reset_fields got pc=%h imm=%h rd=%0d exp 0", o_ex_pc, o_ex_imm, o_ex_rd); end
    checks++; if ({o_re1, o_re2} !== 2'b00) begin errors++; $display("FAIL reset_re got %b exp 00", {o_re1, o_re2}); end
    @(negedge clk);
    rst_n = 1'b1; i_if_valid = 1'b0;
    #1;
    checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", o_id_ready); end
  endtask

  task automatic test_addi;
    @(negedge clk);
    i_if_valid = 1'b1; i_if_inst = 32'h00500093; i_if_pc = 32'h100; i_ex_ready = 1'b1;
    #1;
    checks++; if ({o_id_ready, o_re1, o_raddr1} !== {1'b1, 1'b1, 5'd0})
      begin errors++; $display("FAIL addi_accept got rdy=%0b re1=%0b ra1=%0d exp 1 1 0", o_id_ready, o_re1, o_raddr1); end
    @(negedge clk);
    i_if_valid = 1'b0;
    #1;
    checks++; if ({o_ex_valid, o_ex_rd, o_ex_imm, o_ex_ctrl.reg_we, o_ex_pc} !== {1'b1, 5'd1, 32'd5, 1'b1, 32'h100})
      begin errors++; $display("FAIL addi_ex got v=%0b rd=%0d imm=%h we=%0b pc=%h", o_ex_valid, o_ex_rd, o_ex_imm, o_ex_ctrl.reg_we, o_ex_pc); end
    checks++; if (o_ex_rs1_data !== 32'd0) begin errors++; $display("FAIL addi_rs1data got %h exp 0", o_ex_rs1_data); end
    @(negedge clk); #1;
    checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL addi_bubble got %0b exp 0", o_ex_valid); end
  endtask

  task automatic test_hold;
    @(negedge clk);
    i_if_valid = 1'b1; i_if_inst = 32'h002081B3; i_if_pc = 32'h200; i_ex_ready = 1'b1;
    @(negedge clk);
    i_ex_ready = 1'b0; i_if_inst = 32'h00500093; i_if_pc = 32'h204;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({o_ex_valid, o_ex_rd, o_ex_pc, o_id_ready} !== {1'b1, 5'd3, 32'h200, 1'b0})
        begin errors++; $display("FAIL hold_ex[%0d] got v=%0b rd=%0d pc=%h rdy=%0b", k, o_ex_valid, o_ex_rd, o_ex_pc, o_id_ready); end
      checks++; if ({o_re1, o_re2, o_raddr1, o_raddr2} !== {1'b1, 1'b1, 5'd1, 5'd2})
        begin errors++; $display("FAIL hold_rport[%0d] got re=%b ra1=%0d ra2=%0d exp 11 1 2", k, {o_re1, o_re2}, o_raddr1, o_raddr2); end
      if (k == 0) begin
        checks++; if (o_ex_rs1_data !== 32'h1000_0001) begin errors++; $display("FAIL hold_rs1_old got %h exp 10000001", o_ex_rs1_data); end
      end
      if (k == 1) regs[1] = 32'hDEADBEEF;
      if (k == 2) begin
        checks++; if (o_ex_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rs1_new got %h exp deadbeef", o_ex_rs1_data); end
      end
      @(negedge clk); #1;
    end
    regs[1] = 32'h1000_0001;
    i_ex_ready = 1'b1;
    #1;
    checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %0b exp 1", o_id_ready); end
    @(negedge clk);
    i_if_valid = 1'b0;
    #1;
    checks++; if ({o_ex_valid, o_ex_rd} !== {1'b1, 5'd1}) begin errors++; $display("FAIL hold_next got v=%0b rd=%0d exp 1 1", o_ex_valid, o_ex_rd); end
  endtask

  task automatic test_load_use;
    @(negedge clk);
    i_if_valid = 1'b1; i_if_inst = 32'h00012283; i_ex_ready = 1'b1;
    @(negedge clk);
    i_if_inst = 32'h00128333;
    #1;
    checks++; if ({o_id_ready, o_re1, o_re2} !== 3'b000)
      begin errors++; $display("FAIL lu_stall got rdy=%0b re=%b exp 0 00", o_id_ready, {o_re1, o_re2}); end
    @(negedge clk); #1;
    checks++; if ({o_ex_valid, o_id_ready} !== 2'b01) begin errors++; $display("FAIL lu_bubble got v=%0b rdy=%0b exp 0 1", o_ex_valid, o_id_ready); end
    @(negedge clk);
    i_if_valid = 1'b0;
    #1;
    checks++; if ({o_ex_valid, o_ex_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_issue got v=%0b rd=%0d exp 1 6", o_ex_valid, o_ex_rd); end
    // load to x0 never creates a dependency
    @(negedge clk);
    i_if_valid = 1'b1; i_if_inst = 32'h00012003;
    @(negedge clk);
    i_if_inst = 32'h00100333;
    #1;
    checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_ready got %0b exp 1", o_id_ready); end
    @(negedge clk);
    i_if_valid = 1'b0;
    #1;
    checks++; if ({o_ex_valid, o_ex_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_x0_issue got v=%0b rd=%0d exp 1 6", o_ex_valid, o_ex_rd); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    i_if_valid = 1'b1; i_if_inst = 32'h00500093; i_ex_ready = 1'b1;
    @(negedge clk);
    i_flush = 1'b1; i_ex_ready = 1'b0; i_if_inst = 32'h002081B3;
    #1;
    checks++; if ({o_id_ready, o_re1, o_re2} !== 3'b000)
      begin errors++; $display("FAIL flush_ready got rdy=%0b re=%b exp 0 00", o_id_ready, {o_re1, o_re2}); end
    @(negedge clk);
    i_flush = 1'b0; i_if_valid = 1'b0; i_ex_ready = 1'b1;
    #1;
    checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", o_ex_valid); end
  endtask

  task automatic test_reset_mid_hold;
    @(negedge clk);
    i_if_valid = 1'b1; i_if_inst = 32'h00500093; i_ex_ready = 1'b1;
    @(negedge clk);
    i_if_valid = 1'b0; i_ex_ready = 1'b0;
    #1;
    checks++; if (o_ex_valid !== 1'b1) begin errors++; $display("FAIL mid_hold_valid got %0b exp 1", o_ex_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({o_ex_valid, o_ex_rd} !== {1'b0, 5'd0}) begin errors++; $display("FAIL async_reset got v=%0b rd=%0d exp 0 0", o_ex_valid, o_ex_rd); end
    @(negedge clk);
    rst_n = 1'b1; i_ex_ready = 1'b1;
    #1;
    checks++; if ({o_ex_valid, o_id_ready} !== 2'b01) begin errors++; $display("FAIL post_reset got v=%0b rdy=%0b exp 0 1", o_ex_valid, o_id_ready); end
  endtask

  // back-to-back stream with random EX backpressure, scoreboarded
  task automatic test_back_to_back;
    int    idx = 0;
    bit    mvalid = 1'b0;
    bit    exr, exp_rdy;
    exp_t  e;
    logic [31:0] d1, d2;
    for (int cyc = 0; cyc < 400 && (idx < 12 || q.size() > 0); cyc++) begin
      @(negedge clk);
      checks++; if (o_ex_valid !== mvalid) begin errors++; $display("FAIL stream_valid c%0d got %0b exp %0b", cyc, o_ex_valid, mvalid); end
      if (mvalid && q.size() > 0) begin
        e = q[0];
        checks++;
        if ({o_ex_pc, o_ex_imm, o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_ctrl.reg_we, o_ex_ctrl.mem_rd, o_ex_ctrl.mem_wr,
             o_ex_ctrl.branch, o_ex_ctrl.jump, o_ex_ctrl.illegal} !==
            {e.pc, e.imm, e.rd, e.rs1, e.rs2, e.we, e.mrd, e.mwr, e.br, e.jmp, e.ill}) begin
          errors++;
          $display("FAIL stream_fields inst=%h got pc=%h imm=%h rd=%0d rs=%0d/%0d we%0b mr%0b mw%0b br%0b j%0b il%0b exp pc=%h imm=%h rd=%0d rs=%0d/%0d we%0b mr%0b mw%0b br%0b j%0b il%0b",
                   e.inst, o_ex_pc, o_ex_imm, o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_ctrl.reg_we, o_ex_ctrl.mem_rd, o_ex_ctrl.mem_wr,
                   o_ex_ctrl.branch, o_ex_ctrl.jump, o_ex_ctrl.illegal,
                   e.pc, e.imm, e.rd, e.rs1, e.rs2, e.we, e.mrd, e.mwr, e.br, e.jmp, e.ill);
        end
        d1 = (e.rs1 == 5'd0) ? 32'd0 : regs[e.rs1];
        d2 = (e.rs2 == 5'd0) ? 32'd0 : regs[e.rs2];
        if (e.re1) begin
          checks++; if (o_ex_rs1_data !== d1) begin errors++; $display("FAIL stream_rs1data inst=%h got %h exp %h", e.inst, o_ex_rs1_data, d1); end
        end
        if (e.re2) begin
          checks++; if (o_ex_rs2_data !== d2) begin errors++; $display("FAIL stream_rs2data inst=%h got %h exp %h", e.inst, o_ex_rs2_data, d2); end
        end
      end
      exr = ($urandom_range(0, 3) != 0);
      i_ex_ready = exr;
      i_if_valid = (idx < 12);
      if (idx < 12) begin i_if_inst = tbl[idx].inst; i_if_pc = 32'h1000 + 32'(idx) * 4; end
      #1;
      exp_rdy = !mvalid || exr;
      checks++; if (o_id_ready !== exp_rdy) begin errors++; $display("FAIL stream_ready c%0d got %0b exp %0b", cyc, o_id_ready, exp_rdy); end
      if (!exp_rdy) begin
        checks++; if ({o_re1, o_re2, o_raddr1, o_raddr2} !== {q[0].re1, q[0].re2, q[0].rs1, q[0].rs2})
          begin errors++; $display("FAIL stream_hold_rport got %b %0d %0d exp %b %0d %0d", {o_re1, o_re2}, o_raddr1, o_raddr2, {q[0].re1, q[0].re2}, q[0].rs1, q[0].rs2); end
      end else if (idx < 12) begin
        checks++; if ({o_re1, o_re2, o_raddr1, o_raddr2} !== {tbl[idx].re1, tbl[idx].re2, tbl[idx].rs1, tbl[idx].rs2})
          begin errors++; $display("FAIL stream_rport inst=%h got %b %0d %0d exp %b %0d %0d", tbl[idx].inst, {o_re1, o_re2}, o_raddr1, o_raddr2, {tbl[idx].re1, tbl[idx].re2}, tbl[idx].rs1, tbl[idx].rs2); end
      end
      if (mvalid && exr) void'(q.pop_front());
      if (exp_rdy) begin
        if (idx < 12) begin
          e = tbl[idx]; e.pc = 32'h1000 + 32'(idx) * 4;
          q.push_back(e); idx++; mvalid = 1'b1;
        end else mvalid = 1'b0;
      end
    end
    checks++; if (idx != 12 || q.size() != 0) begin errors++; $display("FAIL stream_timeout issued %0d pending %0d exp 12 0", idx, q.size()); end
    i_if_valid = 1'b0; i_ex_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[0] = '0;
    //           inst          imm           rd  rs1 rs2 re1 re2 we mr mw br j  il
    tbl[0]  = mk(32'h00500093, 32'd5,        1,  0,  0,  1,  0,  1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h002081B3, 32'd0,        3,  1,  2,  1,  1,  1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(32'h00012283, 32'd0,        5,  2,  0,  1,  0,  1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(32'hFE20AE23, 32'hFFFFFFFC, 0,  1,  2,  1,  1,  0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(32'h12345037, 32'h12345000, 0,  0,  0,  0,  0,  1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(32'hFFFFFFFF, 32'd0,        0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(32'h00208463, 32'd8,        0,  1,  2,  1,  1,  0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(32'h010000EF, 32'd16,       1,  0,  0,  0,  0,  1, 0, 0, 0, 1, 0);
    tbl[8]  = mk(32'h404183B3, 32'd0,        7,  3,  4,  1,  1,  1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(32'hFFF40493, 32'hFFFFFFFF, 9,  8,  0,  1,  0,  1, 0, 0, 0, 0, 0);
    tbl[10] = mk(32'h00001517, 32'h00001000, 10, 0,  0,  0,  0,  1, 0, 0, 0, 0, 0);
    tbl[11] = mk(32'h00008067, 32'd0,        0,  1,  0,  1,  0,  1, 0, 0, 0, 1, 0);

    test_reset;
    test_addi;
    test_hold;
    test_load_use;
    test_flush;
    test_reset_mid_hold;
    test_back_to_back;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

endmodule
